// File: rtl/sa_cache_lease_policy_controller.sv
// rtl/sa_cache_lease_policy_controller.sv - set-associative lease priority victim controller
// Optional build macro: SA_LEASE_PER_SET_DECAY_EN limits lease decay to the requested set.
module sa_cache_lease_policy_controller #(
  parameter int WAYS     = 4,
  parameter int SETS     = 64,
  parameter int LEASE_BW = 16,
  localparam int BW_WAY  = $clog2(WAYS),
  localparam int BW_SET  = $clog2(SETS)
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                con_wren_i,
  input  logic [1:0]          con_addr_i,
  input  logic [31:0]         con_data_i,
  input  logic [BW_SET-1:0]   set_i,
  input  logic [BW_WAY-1:0]   way_i,
  input  logic                hit_i,
  input  logic                miss_i,
  input  logic                llt_hit_i,
  input  logic [LEASE_BW-1:0] lease_i,
  output logic                done_o,
  output logic [BW_WAY-1:0]   way_o,
  output logic                swap_o,
  output logic                expired_o,
  output logic                expired_multi_o,
  output logic                default_o,
  output logic                busy_o
);
  localparam int NLINES = SETS * WAYS;
  localparam int BW_IDX = BW_SET + BW_WAY;

  typedef enum logic {ST_NORMAL, ST_GEN} state_t;
  state_t r_state, w_state_nxt;

  logic [LEASE_BW-1:0] r_lease [NLINES];
  logic [LEASE_BW-1:0] w_lease_dec [NLINES];
  logic [NLINES-1:0]   r_dflt;
  logic [SETS-1:0]     r_full;
  logic [BW_WAY-1:0]   r_cold [SETS];
  logic [LEASE_BW-1:0] r_default_lease;
  logic                r_mode;
  logic [15:0]         r_lfsr;
  logic                r_fu_pend;
  logic                r_sv_dflt;
  logic [LEASE_BW-1:0] r_sv_lease;
  logic [BW_SET-1:0]   r_sv_set;
  logic                r_done, r_swap, r_expired, r_expired_multi, r_default;
  logic [BW_WAY-1:0]   r_way;

  logic [LEASE_BW-1:0] w_eff_lease;
  logic [BW_IDX-1:0]   w_hit_idx;
  logic                w_exp_any, w_dflt_any;
  logic [BW_WAY-1:0]   w_exp_way, w_dflt_way;
  logic [BW_WAY:0]     w_exp_cnt;
  logic [15:0]         w_lfsr_nxt;
  logic                w_unused_cfg;

  assign w_eff_lease  = llt_hit_i ? lease_i : r_default_lease;
  assign w_hit_idx    = {set_i, way_i};
  assign w_lfsr_nxt   = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
  assign w_unused_cfg = ^con_data_i[31:LEASE_BW];

  assign done_o          = r_done;
  assign way_o           = r_way;
  assign swap_o          = r_swap;
  assign expired_o       = r_expired;
  assign expired_multi_o = r_expired_multi;
  assign default_o       = r_default;
  assign busy_o          = (r_state == ST_GEN);

  // Saturating decay image of the lease table, committed only on serviced events.
  always_comb begin
    for (int i = 0; i < NLINES; i++) begin
      w_lease_dec[i] = r_lease[i];
`ifdef SA_LEASE_PER_SET_DECAY_EN
      if (r_lease[i] != '0 && BW_SET'(i >> BW_WAY) == set_i)
`else
      if (r_lease[i] != '0)
`endif
        w_lease_dec[i] = r_lease[i] - 1'b1;
    end
  end

  // Lowest-index expired / defaulted way of the saved set.
  always_comb begin
    w_exp_any  = 1'b0;
    w_exp_way  = '0;
    w_exp_cnt  = '0;
    w_dflt_any = 1'b0;
    w_dflt_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_lease[{r_sv_set, BW_WAY'(w)}] == '0) begin
        if (!w_exp_any) w_exp_way = BW_WAY'(w);
        w_exp_any = 1'b1;
        w_exp_cnt = w_exp_cnt + 1'b1;
      end
      if (r_dflt[{r_sv_set, BW_WAY'(w)}] && !w_dflt_any) begin
        w_dflt_way = BW_WAY'(w);
        w_dflt_any = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_NORMAL: if (miss_i && w_eff_lease != '0) w_state_nxt = ST_GEN;
      default:   w_state_nxt = ST_NORMAL;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) r_state <= ST_NORMAL;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int i = 0; i < NLINES; i++) r_lease[i] <= '0;
      for (int s = 0; s < SETS; s++) r_cold[s] <= '0;
      r_dflt          <= '0;
      r_full          <= '0;
      r_default_lease <= '0;
      r_mode          <= 1'b0;
      r_lfsr          <= 16'hACE1;
      r_fu_pend       <= 1'b0;
      r_sv_dflt       <= 1'b0;
      r_sv_lease      <= '0;
      r_sv_set        <= '0;
      r_done          <= 1'b0;
      r_swap          <= 1'b0;
      r_expired       <= 1'b0;
      r_expired_multi <= 1'b0;
      r_default       <= 1'b0;
      r_way           <= '0;
    end else begin
      r_expired       <= 1'b0;
      r_expired_multi <= 1'b0;
      r_default       <= 1'b0;
      if (con_wren_i) begin
        if (con_addr_i == 2'd0) r_default_lease <= con_data_i[LEASE_BW-1:0];
        if (con_addr_i == 2'd1) r_mode <= con_data_i[0];
      end
      if (r_state == ST_NORMAL) begin
        if (miss_i) begin
          r_lease   <= w_lease_dec;
          r_done    <= 1'b0;
          r_default <= !llt_hit_i;
          if (w_eff_lease != '0) begin
            r_sv_lease <= w_eff_lease;
            r_sv_dflt  <= !llt_hit_i;
            r_sv_set   <= set_i;
            r_fu_pend  <= 1'b1;
            r_swap     <= 1'b1;
          end else begin
            r_done    <= 1'b1;
            r_swap    <= 1'b0;
            r_fu_pend <= 1'b0;
          end
        end else if (hit_i) begin
          if (r_fu_pend) begin
            r_lease[w_hit_idx] <= r_sv_lease;
            r_dflt[w_hit_idx]  <= r_sv_dflt;
            r_fu_pend          <= 1'b0;
          end else begin
            // Later NBA to the hit line overrides its decayed value.
            r_lease            <= w_lease_dec;
            r_lease[w_hit_idx] <= w_eff_lease;
            r_dflt[w_hit_idx]  <= !llt_hit_i;
            r_default          <= !llt_hit_i;
          end
        end
      end else begin
        r_done <= 1'b1;
        if (!r_full[r_sv_set]) begin
          r_way            <= r_cold[r_sv_set];
          r_cold[r_sv_set] <= r_cold[r_sv_set] + 1'b1;
          if (r_cold[r_sv_set] == BW_WAY'(WAYS - 1)) r_full[r_sv_set] <= 1'b1;
        end else if (w_exp_any) begin
          r_way           <= w_exp_way;
          r_expired       <= 1'b1;
          r_expired_multi <= (w_exp_cnt >= 2);
        end else if (w_dflt_any && !r_mode) begin
          r_way <= w_dflt_way;
        end else begin
          r_way  <= r_lfsr[BW_WAY-1:0];
          r_lfsr <= w_lfsr_nxt;
        end
      end
    end
  end
endmodule

// File: tb/tb_sa_cache_lease_policy_controller.sv
// tb/tb_sa_cache_lease_policy_controller.sv - randomized check against a behavioural lease-policy model
module tb_sa_cache_lease_policy_controller;
  localparam int WAYS = 4;
  localparam int SETS = 4;
  localparam int LBW  = 8;
`ifdef SA_LEASE_PER_SET_DECAY_EN
  localparam bit PER_SET = 1'b1;
`else
  localparam bit PER_SET = 1'b0;
`endif

  logic        clock_i = 1'b0;
  logic        reset_i, con_wren_i, hit_i, miss_i, llt_hit_i;
  logic [1:0]  con_addr_i, set_i, way_i;
  logic [31:0] con_data_i;
  logic [7:0]  lease_i;
  logic        done_o, swap_o, expired_o, expired_multi_o, default_o, busy_o;
  logic [1:0]  way_o;

  sa_cache_lease_policy_controller #(.WAYS(WAYS), .SETS(SETS), .LEASE_BW(LBW)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .con_wren_i(con_wren_i), .con_addr_i(con_addr_i),
    .con_data_i(con_data_i), .set_i(set_i), .way_i(way_i), .hit_i(hit_i), .miss_i(miss_i),
    .llt_hit_i(llt_hit_i), .lease_i(lease_i), .done_o(done_o), .way_o(way_o), .swap_o(swap_o),
    .expired_o(expired_o), .expired_multi_o(expired_multi_o), .default_o(default_o), .busy_o(busy_o)
  );

  always #5 clock_i = ~clock_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: lease table as plain integers, victim chosen by the priority tiers.
  int m_lease[SETS][WAYS];
  bit m_dflt[SETS][WAYS];
  int m_cold[SETS];
  bit m_full[SETS];
  int m_dl, m_lfsr, m_sv_lease, m_sv_set, m_way;
  bit m_mode, m_fu, m_sv_dflt, m_gen, m_done, m_swap, m_exp, m_expm, m_def;

  function automatic void m_reset();
    for (int a = 0; a < SETS; a++) begin
      m_cold[a] = 0;
      m_full[a] = 0;
      for (int w = 0; w < WAYS; w++) begin
        m_lease[a][w] = 0;
        m_dflt[a][w]  = 0;
      end
    end
    m_dl = 0; m_mode = 0; m_lfsr = 'hACE1; m_fu = 0; m_sv_lease = 0; m_sv_dflt = 0;
    m_sv_set = 0; m_gen = 0; m_done = 0; m_swap = 0; m_exp = 0; m_expm = 0; m_def = 0; m_way = 0;
  endfunction

  function automatic void m_decay(int s);
    for (int a = 0; a < SETS; a++) begin
      if (PER_SET && a != s) continue;
      for (int w = 0; w < WAYS; w++)
        if (m_lease[a][w] > 0) m_lease[a][w] = m_lease[a][w] - 1;
    end
  endfunction

  function automatic void m_pick_victim();
    int s, cnt, first, df;
    s = m_sv_set;
    if (!m_full[s]) begin
      m_way = m_cold[s];
      if (m_cold[s] == WAYS - 1) m_full[s] = 1;
      m_cold[s] = (m_cold[s] + 1) % WAYS;
      return;
    end
    cnt = 0; first = -1; df = -1;
    for (int w = 0; w < WAYS; w++) begin
      if (m_lease[s][w] == 0) begin
        cnt++;
        if (first < 0) first = w;
      end
      if (m_dflt[s][w] && df < 0) df = w;
    end
    if (cnt > 0) begin
      m_way = first; m_exp = 1; m_expm = (cnt >= 2);
    end else if (df >= 0 && !m_mode) begin
      m_way = df;
    end else begin
      m_way = m_lfsr % WAYS;
      if (m_lfsr % 2 == 1) m_lfsr = (m_lfsr / 2) ^ 'hB400;
      else                 m_lfsr = m_lfsr / 2;
    end
  endfunction

  function automatic void model_step(bit rst, bit wr, int ca, int cd, int s, int w,
                                     bit h, bit m, bit llt, int ls);
    int eff;
    m_exp = 0; m_expm = 0; m_def = 0;
    if (rst) begin
      m_reset();
      return;
    end
    if (!m_gen) begin
      if (m) begin
        eff = llt ? ls : m_dl;
        m_decay(s);
        m_done = 0;
        m_def  = !llt;
        if (eff != 0) begin
          m_sv_lease = eff; m_sv_dflt = !llt; m_sv_set = s; m_fu = 1; m_swap = 1; m_gen = 1;
        end else begin
          m_done = 1; m_swap = 0; m_fu = 0;
        end
      end else if (h) begin
        if (m_fu) begin
          m_lease[s][w] = m_sv_lease; m_dflt[s][w] = m_sv_dflt; m_fu = 0;
        end else begin
          m_decay(s);
          m_lease[s][w] = llt ? ls : m_dl;
          m_dflt[s][w]  = !llt;
          m_def         = !llt;
        end
      end
    end else begin
      m_pick_victim();
      m_gen  = 0;
      m_done = 1;
    end
    if (wr) begin
      if (ca == 0) m_dl = cd % 256;
      if (ca == 1) m_mode = cd[0];
    end
  endfunction

  task automatic compare_all();
    check("done", done_o, m_done);
    check("way", way_o, m_way);
    check("swap", swap_o, m_swap);
    check("expired", expired_o, m_exp);
    check("expired_multi", expired_multi_o, m_expm);
    check("default", default_o, m_def);
    check("busy", busy_o, m_gen);
  endtask

  task automatic drive(input bit rst, input bit wr, input int ca, input int cd, input int s,
                       input int w, input bit h, input bit m, input bit llt, input int ls);
    reset_i = rst; con_wren_i = wr; con_addr_i = ca[1:0]; con_data_i = cd;
    set_i = s[1:0]; way_i = w[1:0]; hit_i = h; miss_i = m; llt_hit_i = llt; lease_i = ls[7:0];
    @(posedge clock_i);
    model_step(rst, wr, ca, cd, s, w, h, m, llt, ls);
    #1;
    compare_all();
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    m_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("reset_done", done_o, 0);

    // Cold fill of set 2, each allocation followed by its follow-up hit.
    for (int k = 0; k < WAYS; k++) begin
      drive(0, 0, 0, 0, 2, 0, 0, 1, 1, 5);
      check("cold_busy", busy_o, 1);
      idle();
      check("cold_way", way_o, k);
      check("cold_swap", swap_o, 1);
      drive(0, 0, 0, 0, 2, k, 1, 0, 1, 9);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 5);
    idle();
    check("set0_cold_way", way_o, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 1, 5);

    // Zero effective lease: decision one cycle later, no allocation.
    drive(0, 0, 0, 0, 3, 0, 0, 1, 1, 0);
    check("zero_done", done_o, 1);
    check("zero_swap", swap_o, 0);
    drive(0, 0, 0, 0, 2, 1, 1, 0, 1, 7);

    // Default tier and mode configuration, then traffic into the full set.
    drive(0, 1, 0, 3, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 2, 2, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 2, 0, 0, 1, 1, 6);
    idle();
    drive(0, 1, 1, 1, 2, 0, 0, 1, 1, 6);
    idle();
    drive(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);

    // Reset while the victim is being generated.
    drive(0, 0, 0, 0, 1, 0, 0, 1, 1, 7);
    check("pre_rst_busy", busy_o, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_gen_done", done_o, 0);
    check("rst_gen_busy", busy_o, 0);
    drive(0, 0, 0, 0, 2, 0, 0, 1, 1, 5);
    idle();
    check("rst_cold_way", way_o, 0);

    for (int n = 0; n < 4000; n++) begin
      int r, s, w, ls, ca, cd;
      bit h, m, llt, wr;
      r   = $urandom_range(0, 99);
      s   = $urandom_range(0, SETS - 1);
      w   = ($urandom_range(0, 1) == 1) ? m_way : $urandom_range(0, WAYS - 1);
      ls  = $urandom_range(0, 12);
      llt = ($urandom_range(0, 3) != 0);
      h   = (r >= 40 && r < 65) || r >= 95;
      m   = (r >= 65);
      wr  = ($urandom_range(0, 19) == 0);
      ca  = $urandom_range(0, 3);
      cd  = (ca == 0) ? $urandom_range(0, 6) : $urandom_range(0, 3);
      drive(0, wr, ca, cd, s, w, h, m, llt, ls);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
